gpio_uart_bridge: RTL and testbench

GPIO_UART_BRIDGE -- requirements
Module: gpio_uart_bridge

---
 rtl/gpio_pkg.sv | 21 ++
 rtl/sync_fifo.sv | 59 +++++
 rtl/gpio_uart_bridge.sv | 157 +++++++++++++++
 tb/tb_gpio_uart_bridge.sv | 251 +++++++++++++++++++++++++
 4 files changed

// File: rtl/gpio_pkg.sv
// Shared definitions for the GPIO-to-UART bridge: TX FSM states,
// register offsets and control-register bit positions.
package gpio_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      START = 2'd1,
      DATA  = 2'd2,
      STOP  = 2'd3
   } tx_state_t;

   // Register offsets relative to BASE_ADDR
   localparam logic [31:0] DATA_OFS = 32'd0;
   localparam logic [31:0] CTRL_OFS = 32'd1;

   // Control register bit positions
   localparam int CTRL_TX_EN_BIT  = 0;
   localparam int CTRL_FLUSH_BIT  = 1;
   localparam int CTRL_CLR_OVF_BIT = 2;

endpackage

// File: rtl/sync_fifo.sv
// Synchronous byte FIFO with flush. A push while full is accepted only
// when a pop happens at the same edge; flush beats both push and pop.
module sync_fifo #(
   parameter int DEPTH = 8,
   parameter int WIDTH = 8
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     push,
   input  logic                     pop,
   input  logic                     flush,
   input  logic [WIDTH-1:0]         wr_data,
   output logic [WIDTH-1:0]         rd_data,
   output logic                     full,
   output logic                     empty,
   output logic [$clog2(DEPTH):0]   count
);

   localparam int AW = $clog2(DEPTH);

   logic [WIDTH-1:0] mem [DEPTH];
   logic [AW-1:0]    wr_ptr;
   logic [AW-1:0]    rd_ptr;
   logic             do_push;
   logic             do_pop;

   assign full    = (count == (AW+1)'(DEPTH));
   assign empty   = (count == '0);
   assign do_pop  = pop && !empty;
   assign do_push = push && (!full || do_pop);
   assign rd_data = mem[rd_ptr];

   // Storage write
   // NOTE: the storage array has no reset; count and pointers alone decide
   // which entries are valid, so clearing the array would only cost logic.
   always_ff @(posedge clk) begin
      if (do_push) mem[wr_ptr] <= wr_data;
   end

   // Pointers and occupancy; pointers wrap naturally at the power-of-two depth
   // NOTE: state registers use non-blocking assignments so every register
   // samples pre-edge values regardless of statement order.
   always_ff @(posedge clk) begin
      if (rst || flush) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (do_push) wr_ptr <= wr_ptr + 1'b1;
         if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
         case ({do_push, do_pop})
            2'b10:   count <= count + 1'b1;
            2'b01:   count <= count - 1'b1;
            default: ;
         endcase
      end
   end

endmodule

// File: rtl/gpio_uart_bridge.sv
// GPIO-mapped UART transmitter: data-register writes queue bytes in a FIFO,
// a control register gates transmission, flushes the queue and clears the
// sticky overflow flag. Frames are 8N1, LSB first, with a registered tx.
module gpio_uart_bridge
   import gpio_pkg::*;
#(
   parameter logic [31:0] BASE_ADDR    = 32'h0000_0400,
   parameter int          FIFO_DEPTH   = 8,
   parameter int          CLKS_PER_BIT = 4
) (
   input  logic                          clk,
   input  logic                          rst,
   input  logic [31:0]                   GPIOaddr,
   input  logic [7:0]                    GPIO,
   input  logic                          GPIOEn,
   output logic                          tx,
   output logic                          busy,
   output logic [$clog2(FIFO_DEPTH):0]   fifo_count,
   output logic                          overflow
);

   localparam int             BW        = $clog2(CLKS_PER_BIT);
   localparam logic [BW-1:0]  BAUD_LAST = BW'(CLKS_PER_BIT - 1);

   tx_state_t     state, state_next;
   logic [BW-1:0] baud_cnt, baud_next;
   logic [2:0]    bit_cnt, bit_next;
   logic [7:0]    shift_reg, shift_next;
   logic          tx_next;
   logic          baud_end;
   logic          pop;

   logic          tx_enable;
   logic          data_wr, ctrl_wr;
   logic          flush, ovf_set, ovf_clr;
   logic          fifo_full, fifo_empty;
   logic [7:0]    fifo_data;

   assign data_wr  = GPIOEn && (GPIOaddr == BASE_ADDR + DATA_OFS);
   assign ctrl_wr  = GPIOEn && (GPIOaddr == BASE_ADDR + CTRL_OFS);
   assign flush    = ctrl_wr && GPIO[CTRL_FLUSH_BIT];
   assign ovf_clr  = ctrl_wr && GPIO[CTRL_CLR_OVF_BIT];
   assign ovf_set  = data_wr && fifo_full && !pop;
   assign baud_end = (baud_cnt == BAUD_LAST);
   assign busy     = (state != IDLE);

   sync_fifo #(
      .DEPTH (FIFO_DEPTH),
      .WIDTH (8)
   ) u_fifo (
      .clk     (clk),
      .rst     (rst),
      .push    (data_wr),
      .pop     (pop),
      .flush   (flush),
      .wr_data (GPIO),
      .rd_data (fifo_data),
      .full    (fifo_full),
      .empty   (fifo_empty),
      .count   (fifo_count)
   );

   // Control register and sticky overflow (set wins over clear)
   always_ff @(posedge clk) begin
      if (rst) begin
         tx_enable <= 1'b1;
         overflow  <= 1'b0;
      end else begin
         if (ctrl_wr) tx_enable <= GPIO[CTRL_TX_EN_BIT];
         if (ovf_set)      overflow <= 1'b1;
         else if (ovf_clr) overflow <= 1'b0;
      end
   end

   // TX next-state, counters, shift register and next line level
   // NOTE: every output of this block gets a default first, so no path can
   // leave a value unassigned and infer a latch.
   always_comb begin
      state_next = state;
      baud_next  = baud_cnt;
      bit_next   = bit_cnt;
      shift_next = shift_reg;
      pop        = 1'b0;
      unique case (state)
         IDLE: begin
            if (tx_enable && !fifo_empty) begin
               pop        = 1'b1;
               state_next = START;
               shift_next = fifo_data;
               baud_next  = '0;
               bit_next   = '0;
            end
         end
         START: begin
            if (baud_end) begin
               state_next = DATA;
               baud_next  = '0;
            end else begin
               baud_next = baud_cnt + 1'b1;
            end
         end
         DATA: begin
            if (baud_end) begin
               baud_next  = '0;
               shift_next = shift_reg >> 1;
               if (bit_cnt == 3'd7) begin
                  state_next = STOP;
                  bit_next   = '0;
               end else begin
                  bit_next = bit_cnt + 1'b1;
               end
            end else begin
               baud_next = baud_cnt + 1'b1;
            end
         end
         STOP: begin
            if (baud_end) begin
               baud_next = '0;
               if (tx_enable && !fifo_empty) begin
                  pop        = 1'b1;
                  state_next = START;
                  shift_next = fifo_data;
                  bit_next   = '0;
               end else begin
                  state_next = IDLE;
               end
            end else begin
               baud_next = baud_cnt + 1'b1;
            end
         end
         default: state_next = IDLE;
      endcase

      // Line level for the state being entered, so tx is a pure register
      if (state_next == START)     tx_next = 1'b0;
      else if (state_next == DATA) tx_next = shift_next[0];
      else                         tx_next = 1'b1;
   end

   // TX state register, counters and registered line output
   always_ff @(posedge clk) begin
      if (rst) begin
         state     <= IDLE;
         baud_cnt  <= '0;
         bit_cnt   <= '0;
         shift_reg <= '0;
         tx        <= 1'b1;
      end else begin
         state     <= state_next;
         baud_cnt  <= baud_next;
         bit_cnt   <= bit_next;
         shift_reg <= shift_next;
         tx        <= tx_next;
      end
   end

endmodule

// File: tb/tb_gpio_uart_bridge.sv
// Self-checking bench for gpio_uart_bridge: directed frame sequences,
// a table of register-write vectors, and randomized traffic compared each
// cycle against a frame-timing reference model.
module tb_gpio_uart_bridge;

   localparam logic [31:0] BASE  = 32'h0000_0400;
   localparam int          DEPTH = 8;
   localparam int          CPB   = 4;
   localparam int          FRAME = 10 * CPB;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic [31:0] GPIOaddr = '0;
   logic [7:0]  GPIO = '0;
   logic        GPIOEn = 1'b0;
   logic        tx, busy, overflow;
   logic [3:0]  fifo_count;

   int checks = 0;
   int errors = 0;
   bit mon_on = 1'b0;

   gpio_uart_bridge #(
      .BASE_ADDR    (BASE),
      .FIFO_DEPTH   (DEPTH),
      .CLKS_PER_BIT (CPB)
   ) dut (
      .clk        (clk),
      .rst        (rst),
      .GPIOaddr   (GPIOaddr),
      .GPIO       (GPIO),
      .GPIOEn     (GPIOEn),
      .tx         (tx),
      .busy       (busy),
      .fifo_count (fifo_count),
      .overflow   (overflow)
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // Line level t cycles into a frame: start bit, 8 data bits LSB first, stop
   function automatic logic frame_bit(input logic [7:0] b, input int t);
      int k;
      k = t / CPB;
      if (k == 0)      return 1'b0;
      else if (k <= 8) return b[k-1];
      else             return 1'b1;
   endfunction

   // Reference model: a byte queue plus a frame timer
   logic [7:0] m_q[$];
   logic [7:0] m_cur;
   bit         m_active = 1'b0;
   bit         m_en = 1'b1;
   bit         m_ovf = 1'b0;
   int         m_t = 0;

   always @(posedge clk) begin
      bit do_pop, wr_d, wr_c, full;
      if (rst) begin
         m_q.delete();
         m_active = 1'b0;
         m_t      = 0;
         m_ovf    = 1'b0;
         m_en     = 1'b1;
      end else begin
         wr_d   = GPIOEn && (GPIOaddr == BASE);
         wr_c   = GPIOEn && (GPIOaddr == BASE + 32'd1);
         full   = (m_q.size() == DEPTH);
         do_pop = m_en && (m_q.size() > 0) && (!m_active || m_t == FRAME - 1);
         if (do_pop) begin
            m_cur    = m_q.pop_front();
            m_active = 1'b1;
            m_t      = 0;
         end else if (m_active) begin
            if (m_t == FRAME - 1) m_active = 1'b0;
            else                  m_t++;
         end
         if (wr_d) begin
            if (!full || do_pop) m_q.push_back(GPIO);
            else                 m_ovf = 1'b1;
         end
         if (wr_c) begin
            m_en = GPIO[0];
            if (GPIO[1]) m_q.delete();
            if (GPIO[2]) m_ovf = 1'b0;
         end
      end
   end

   // Cycle-by-cycle comparison against the model, away from the active edge
   always @(negedge clk) begin
      if (mon_on) begin
         check("mon_tx", tx, m_active ? frame_bit(m_cur, m_t) : 1'b1);
         check("mon_busy", busy, m_active);
         check("mon_count", fifo_count, m_q.size());
         check("mon_ovf", overflow, m_ovf);
      end
   end

   // One register write; called at a negedge, returns at the next negedge
   task automatic write(input logic [31:0] a, input logic [7:0] d);
      GPIOaddr = a;
      GPIO     = d;
      GPIOEn   = 1'b1;
      @(negedge clk);
      GPIOEn   = 1'b0;
   endtask

   task automatic idle(input int n);
      repeat (n) @(negedge clk);
   endtask

   // Single byte into an empty, idle, enabled bridge
   task automatic send_and_check(input logic [7:0] b);
      write(BASE, b);
      check("single_pre_tx", tx, 1'b1);
      check("single_pre_count", fifo_count, 1);
      for (int i = 0; i < FRAME; i++) begin
         @(negedge clk);
         check("single_tx", tx, frame_bit(b, i));
         check("single_busy", busy, 1'b1);
      end
      @(negedge clk);
      check("single_end_busy", busy, 1'b0);
      check("single_end_tx", tx, 1'b1);
   endtask

   typedef struct {
      logic [31:0] addr;
      logic [7:0]  data;
      int          exp_count;
      bit          exp_ovf;
   } vec_t;

   vec_t       vecs[$];
   int         r;
   logic [2:0] c;

   initial begin
      // Register-write vectors, starting from a freshly reset, empty bridge
      vecs.push_back('{BASE + 32'd1, 8'h00, 0, 1'b0});       // disable tx
      for (int i = 0; i < 8; i++)
         vecs.push_back('{BASE, 8'(8'h10 + i), i + 1, 1'b0});
      vecs.push_back('{BASE, 8'hEE, 8, 1'b1});               // ninth byte dropped
      vecs.push_back('{BASE + 32'd1, 8'h04, 8, 1'b0});       // clear overflow
      vecs.push_back('{BASE + 32'd2, 8'h55, 8, 1'b0});       // unmapped address
      vecs.push_back('{32'h0000_0000, 8'h55, 8, 1'b0});      // unmapped address
      vecs.push_back('{BASE + 32'd1, 8'h01, 8, 1'b0});       // enable
      vecs.push_back('{BASE, 8'h77, 8, 1'b0});               // push+pop while full
      vecs.push_back('{BASE + 32'd1, 8'h02, 0, 1'b0});       // flush, disable

      rst = 1'b1;
      idle(3);
      rst = 1'b0;
      mon_on = 1'b1;
      check("reset_tx", tx, 1'b1);
      check("reset_busy", busy, 1'b0);
      check("reset_count", fifo_count, 0);
      check("reset_ovf", overflow, 1'b0);

      // Single byte frame
      send_and_check(8'hA5);
      idle(5);

      // Back-to-back frames with no idle gap
      write(BASE, 8'h00);
      write(BASE, 8'hFF);
      for (int i = 0; i < 2 * FRAME; i++) begin
         check("b2b_tx", tx, frame_bit((i < FRAME) ? 8'h00 : 8'hFF, i % FRAME));
         check("b2b_busy", busy, 1'b1);
         @(negedge clk);
      end
      check("b2b_end_busy", busy, 1'b0);
      idle(5);

      // Flush during the first of three frames
      write(BASE, 8'h11);
      write(BASE, 8'h22);
      write(BASE, 8'h33);
      idle(10);
      write(BASE + 32'd1, 8'h03);
      check("flush_count", fifo_count, 0);
      check("flush_busy", busy, 1'b1);
      idle(FRAME);
      check("flush_end_busy", busy, 1'b0);
      check("flush_end_tx", tx, 1'b1);
      check("flush_end_count", fifo_count, 0);
      idle(5);

      // Reset during DATA, then a clean frame
      write(BASE, 8'h55);
      write(BASE, 8'h66);
      idle(10);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      check("rst_mid_tx", tx, 1'b1);
      check("rst_mid_busy", busy, 1'b0);
      check("rst_mid_count", fifo_count, 0);
      check("rst_mid_ovf", overflow, 1'b0);
      idle(2);
      check("rst_idle_tx", tx, 1'b1);
      send_and_check(8'h3C);
      idle(5);

      // Table-driven register vectors
      foreach (vecs[i]) begin
         write(vecs[i].addr, vecs[i].data);
         check($sformatf("vec%0d_count", i), fifo_count, vecs[i].exp_count);
         check($sformatf("vec%0d_ovf", i), overflow, vecs[i].exp_ovf);
      end
      idle(FRAME + 5);
      check("vec_end_busy", busy, 1'b0);
      write(BASE + 32'd1, 8'h01);

      // Randomized traffic, checked by the monitor every cycle
      for (int n = 0; n < 3000; n++) begin
         r = $urandom_range(0, 99);
         if (r < 2) begin
            rst = 1'b1;
            @(negedge clk);
            rst = 1'b0;
         end else if (r < 30) begin
            write(BASE, 8'($urandom));
         end else if (r < 36) begin
            c[0] = ($urandom_range(0, 3) != 0);
            c[1] = ($urandom_range(0, 7) == 0);
            c[2] = 1'($urandom);
            write(BASE + 32'd1, {5'b0, c});
         end else if (r < 40) begin
            write(32'($urandom), 8'($urandom));
         end else begin
            @(negedge clk);
         end
      end
      idle(FRAME * 2);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
